mux_n_to_1_stream: RTL and testbench

//  Parametrised, registered successor to the fixed 100:1 output mux in the convolution datapath.

---
 rtl/mux_n_to_1_stream_if.sv | 38 +++
 rtl/mux_n_to_1_stream.sv | 120 ++++++++++++
 tb/tb_mux_n_to_1_stream.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_to_1_stream_if.sv
// rtl/mux_n_to_1_stream_if.sv - request/beat bundle for mux_n_to_1_stream
// sel_err is present only when MUX_SEL_ERR_EN is defined.
interface mux_n_to_1_stream_if #(
   parameter int NUM_IN     = 100,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = $clog2(NUM_IN + 1)
);
   logic [NUM_IN*DATA_WIDTH-1:0] in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic                         mode;
   logic [SEL_WIDTH-1:0]         sel;
   logic [DATA_WIDTH-1:0]        out_data;
   logic [SEL_WIDTH-1:0]         out_idx;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_last;
   logic                         busy;
`ifdef MUX_SEL_ERR_EN
   logic                         sel_err;
`endif

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_idx, out_valid, out_last, busy
`ifdef MUX_SEL_ERR_EN
      , output sel_err
`endif
   );

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_idx, out_valid, out_last, busy
`ifdef MUX_SEL_ERR_EN
      , input sel_err
`endif
   );
endinterface

// File: rtl/mux_n_to_1_stream.sv
// rtl/mux_n_to_1_stream.sv - registered N:1 channel mux with DIRECT and SCAN streaming modes
// Optional out-of-range select flag via MUX_SEL_ERR_EN.
module mux_n_to_1_stream #(
   parameter int NUM_IN     = 100,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = $clog2(NUM_IN + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mux_n_to_1_stream_if.slave     bus
);
   localparam int                   BUS_W    = NUM_IN * DATA_WIDTH;
   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_IN);
   localparam logic [SEL_WIDTH-1:0] ONE_IDX  = SEL_WIDTH'(1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                  state, state_nxt;
   logic [BUS_W-1:0]        scan_buf, scan_buf_nxt;
   logic [DATA_WIDTH-1:0]   data_q, data_nxt;
   logic [SEL_WIDTH-1:0]    idx_q, idx_nxt;
   logic                    valid_q, valid_nxt;
   logic                    last_q, last_nxt;
   logic                    ready, accept, out_hs, sel_bad;
`ifdef MUX_SEL_ERR_EN
   logic                    err_q, err_nxt;
`endif

   // Channel k (1-based) of a packed bus; callers guarantee 1 <= k <= NUM_IN.
   function automatic logic [DATA_WIDTH-1:0] pick(input logic [BUS_W-1:0] vec,
                                                  input logic [SEL_WIDTH-1:0] k);
      logic [BUS_W-1:0] sh;
      sh = vec >> ((int'(k) - 1) * DATA_WIDTH);
      return sh[DATA_WIDTH-1:0];
   endfunction

   assign ready   = (state == IDLE && (!valid_q || bus.out_ready)) ||
                    (state == SCAN && last_q && bus.out_ready);
   assign accept  = bus.in_valid && ready;
   assign out_hs  = valid_q && bus.out_ready;
   assign sel_bad = (bus.sel == '0) || (bus.sel > LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         scan_buf <= '0;
         data_q   <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
`ifdef MUX_SEL_ERR_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         scan_buf <= scan_buf_nxt;
         data_q   <= data_nxt;
         idx_q    <= idx_nxt;
         valid_q  <= valid_nxt;
         last_q   <= last_nxt;
`ifdef MUX_SEL_ERR_EN
         err_q    <= err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      scan_buf_nxt = scan_buf;
      data_nxt     = data_q;
      idx_nxt      = idx_q;
      valid_nxt    = valid_q;
      last_nxt     = last_q;
`ifdef MUX_SEL_ERR_EN
      err_nxt      = err_q;
`endif
      if (accept && !bus.mode) begin
         state_nxt = IDLE;
         data_nxt  = sel_bad ? '0 : pick(bus.in_data, bus.sel);
         idx_nxt   = bus.sel;
         valid_nxt = 1'b1;
         last_nxt  = 1'b1;
`ifdef MUX_SEL_ERR_EN
         err_nxt   = sel_bad;
`endif
      end else if (accept) begin
         state_nxt    = SCAN;
         scan_buf_nxt = bus.in_data;
         data_nxt     = pick(bus.in_data, ONE_IDX);
         idx_nxt      = ONE_IDX;
         valid_nxt    = 1'b1;
         last_nxt     = 1'b0;
`ifdef MUX_SEL_ERR_EN
         err_nxt      = 1'b0;
`endif
      end else if (out_hs && state == SCAN && !last_q) begin
         // Advance only while below NUM_IN, so the counter cannot wrap.
         idx_nxt  = idx_q + ONE_IDX;
         data_nxt = pick(scan_buf, idx_q + ONE_IDX);
         last_nxt = ((idx_q + ONE_IDX) == LAST_IDX);
      end else if (out_hs) begin
         state_nxt = IDLE;
         valid_nxt = 1'b0;
         last_nxt  = 1'b0;
`ifdef MUX_SEL_ERR_EN
         err_nxt   = 1'b0;
`endif
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_data  = data_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_valid = valid_q;
   assign bus.out_last  = last_q;
   assign bus.busy      = (state == SCAN);
`ifdef MUX_SEL_ERR_EN
   assign bus.sel_err   = err_q;
`endif
endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// tb/tb_mux_n_to_1_stream.sv - self-checking bench for mux_n_to_1_stream
// Exercises sel_err as well when MUX_SEL_ERR_EN is defined.
module tb_mux_n_to_1_stream;
   localparam int NUM_IN = 100;
   localparam int DW     = 32;
   localparam int SW     = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_n_to_1_stream_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

   mux_n_to_1_stream #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] chan [1:NUM_IN];
   for (genvar k = 1; k <= NUM_IN; k++) begin : g_pack
      assign bus.in_data[k*DW-1 -: DW] = chan[k];
   end

   typedef struct packed {
      logic [31:0] d;
      logic [6:0]  idx;
      logic        last;
      logic        err;
   } beat_t;

   typedef struct {
      logic [6:0]  sel;
      logic [31:0] d;
      logic        err;
   } vec_t;

   beat_t sb[$];
   int    n_pass  = 0;
   int    n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: expectations are queued at the input handshake, compared at the output handshake.
   always @(negedge clk) begin
      beat_t b, act;
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow: got beat idx %0d expected none", bus.out_idx);
            end else begin
               b        = sb.pop_front();
               act.d    = bus.out_data;
               act.idx  = bus.out_idx;
               act.last = bus.out_last;
`ifdef MUX_SEL_ERR_EN
               act.err  = bus.sel_err;
`else
               act.err  = 1'b0;
               b.err    = 1'b0;
`endif
               check("beat", 64'(act), 64'(b));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            if (!bus.mode) begin
               b.idx  = bus.sel;
               b.last = 1'b1;
               b.err  = (bus.sel == 7'd0) || (bus.sel > 7'd100);
               if (b.err) b.d = 32'h0;
               else       b.d = chan[bus.sel];
               sb.push_back(b);
            end else begin
               for (int k = 1; k <= NUM_IN; k++) begin
                  b.d    = chan[7'(k)];
                  b.idx  = 7'(k);
                  b.last = (k == NUM_IN);
                  b.err  = 1'b0;
                  sb.push_back(b);
               end
            end
         end
      end
   end

   task automatic send(input logic m, input logic [6:0] s);
      logic ok;
      ok = 1'b0;
      bus.mode     = m;
      bus.sel      = s;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("send_handshake", 64'(ok), 64'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idx(input logic [6:0] target);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_idx == target) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_idx", 64'(ok), 64'(1));
   endtask

   task automatic wait_done();
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!bus.out_valid && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_done", 64'(ok), 64'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs [6];
      logic ok;
      int   beats, ir_bad, busy_bad;

      vecs[0] = '{sel: 7'd37,  d: 32'h1025, err: 1'b0};
      vecs[1] = '{sel: 7'd0,   d: 32'h0,    err: 1'b1};
      vecs[2] = '{sel: 7'd101, d: 32'h0,    err: 1'b1};
      vecs[3] = '{sel: 7'd1,   d: 32'h1001, err: 1'b0};
      vecs[4] = '{sel: 7'd100, d: 32'h1064, err: 1'b0};
      vecs[5] = '{sel: 7'd127, d: 32'h0,    err: 1'b1};

      for (int k = 1; k <= NUM_IN; k++) chan[7'(k)] = 32'h1000 + 32'(k);
      bus.in_valid  = 1'b0;
      bus.mode      = 1'b0;
      bus.sel       = 7'd0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(bus.out_valid), 64'(0));
      check("reset_out_data",  64'(bus.out_data),  64'(0));
      check("reset_out_idx",   64'(bus.out_idx),   64'(0));
      check("reset_last_busy", 64'({bus.out_last, bus.busy}), 64'(0));
      check("reset_in_ready",  64'(bus.in_ready),  64'(1));
`ifdef MUX_SEL_ERR_EN
      check("reset_sel_err",   64'(bus.sel_err),   64'(0));
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         send(1'b0, vecs[i].sel);
         @(negedge clk);
         check("direct_valid_last", 64'({bus.out_valid, bus.out_last}), 64'(2'b11));
         check("direct_data", 64'(bus.out_data), 64'(vecs[i].d));
         check("direct_idx",  64'(bus.out_idx),  64'(vecs[i].sel));
`ifdef MUX_SEL_ERR_EN
         check("direct_sel_err", 64'(bus.sel_err), 64'(vecs[i].err));
`endif
         @(posedge clk); #1;
      end

      // Back-to-back DIRECT requests at one beat per cycle
      bus.mode     = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.sel = 7'(5 + i);
         @(negedge clk);
         check("b2b_in_ready", 64'(bus.in_ready), 64'(1));
         if (i > 0) check("b2b_idx", 64'(bus.out_idx), 64'(4 + i));
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("b2b_final_idx", 64'(bus.out_idx), 64'(9));
      @(posedge clk); #1;

      // Full SCAN with downstream always ready
      send(1'b1, 7'd0);
      beats = 0; ir_bad = 0; busy_bad = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            beats++;
            if (bus.in_ready != (bus.out_idx == 7'd100)) ir_bad++;
            if (!bus.busy) busy_bad++;
            if (bus.out_last) break;
         end
      end
      check("scan_beats",     64'(beats),    64'(100));
      check("scan_in_ready",  64'(ir_bad),   64'(0));
      check("scan_busy",      64'(busy_bad), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("scan_end", 64'({bus.out_valid, bus.busy}), 64'(0));
      @(posedge clk); #1;

      // Stall at idx 10 while the inputs change underneath
      send(1'b1, 7'd0);
      wait_idx(7'd9);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) chan[7'(k)] = 32'hDEAD0000 + 32'(k);
      bus.mode = 1'b0;
      bus.sel  = 7'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_data", 64'(bus.out_data), 64'(32'h100A));
         check("stall_idx",  64'(bus.out_idx),  64'(10));
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("resume_idx",  64'(bus.out_idx),  64'(11));
      check("resume_data", 64'(bus.out_data), 64'(32'h100B));
      wait_done();
      for (int k = 1; k <= NUM_IN; k++) chan[7'(k)] = 32'h1000 + 32'(k);

      // Asynchronous reset in the middle of a scan
      send(1'b1, 7'd0);
      wait_idx(7'd50);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 64'(bus.out_valid), 64'(0));
      check("rst_mid_busy",  64'(bus.busy),      64'(0));
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_no_resume", 64'({bus.out_valid, bus.busy}), 64'(0));
      @(posedge clk); #1;
      send(1'b0, 7'd3);
      @(negedge clk);
      check("post_rst_data", 64'(bus.out_data), 64'(32'h1003));
      check("post_rst_idx",  64'(bus.out_idx),  64'(3));
      @(posedge clk); #1;

      // Two scans back-to-back: seamless handoff at the last beat
      send(1'b1, 7'd0);
      bus.mode     = 1'b1;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("handoff_hs",       64'(ok),           64'(1));
      check("handoff_last_idx", 64'(bus.out_idx),  64'(100));
      check("handoff_last",     64'(bus.out_last), 64'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("handoff_next", 64'({bus.out_valid, bus.busy, bus.out_idx}), 64'({2'b11, 7'd1}));
      wait_done();

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
